// File: rtl/digit_serial_addsub.sv
// ---------------------------------------------------------------------------
// digit_serial_addsub
//   Digit-serial two's-complement adder/subtractor. Operands are captured on
//   an accepted start, then DIGIT bits are summed per clock (LSB digit first)
//   through a ripple full-adder chain, so a WIDTH-bit result takes
//   NDIG = WIDTH/DIGIT cycles. WIDTH must be an integer multiple of DIGIT.
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   start in   begin an operation (accepted in IDLE or DONE only)
//   sub   in   0: S = A + B + Cin, 1: S = A - B (Cin ignored)
//   A, B  in   WIDTH-bit operands
//   Cin   in   carry-in for add mode
//   S     out  WIDTH-bit result (registered)
//   Cout  out  carry out of the MSB (sub mode: 1 = no borrow)
//   V     out  signed overflow
//   busy  out  high while an operation is in progress
//   done  out  one-cycle pulse marking S/Cout/V valid
// ---------------------------------------------------------------------------
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             busy,
    output logic             done
);

    localparam int NDIG = WIDTH / DIGIT;
    // Counter must be able to hold NDIG after the last digit without wrapping.
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [DIGIT-1:0] DMASK = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // already inverted in sub mode
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic [CW-1:0]    k_q;
    logic             cout_q;
    logic             v_q;
    logic             busy_q;
    logic             done_q;

    int unsigned      base;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic [DIGIT-1:0] dig_sum;
    logic             c_d;      // carry out of the current digit
    logic             c_msb;    // carry into the top bit of the current digit
    logic [WIDTH-1:0] s_d;
    logic             last_dig;

    // One digit of the ripple chain plus merge of the digit into the result.
    always_comb begin
        base    = 32'(k_q) * 32'(DIGIT);
        dig_a   = DIGIT'(a_q >> base);
        dig_b   = DIGIT'(b_q >> base);
        dig_sum = '0;
        c_d     = c_q;
        c_msb   = c_q;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            dig_sum[i] = dig_a[i] ^ dig_b[i] ^ c_d;
            c_msb      = c_d;
            c_d        = (dig_a[i] & dig_b[i]) | (c_d & (dig_a[i] ^ dig_b[i]));
        end
        s_d      = (s_q & ~(WIDTH'(DMASK) << base)) | (WIDTH'(dig_sum) << base);
        last_dig = (k_q == CW'(NDIG - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            k_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        // A - B is done as A + ~B + 1.
                        a_q     <= A;
                        b_q     <= sub ? ~B : B;
                        c_q     <= sub ? 1'b1 : Cin;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    s_q <= s_d;
                    c_q <= c_d;
                    k_q <= k_q + CW'(1);
                    if (last_dig) begin
                        cout_q  <= c_d;
                        v_q     <= c_d ^ c_msb;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign V    = v_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_digit_serial_addsub
//   Bench for digit_serial_addsub: a 16/4 instance and a 16/16 instance share
//   operand inputs; use1 selects which one is started and observed.
// ---------------------------------------------------------------------------
module tb_digit_serial_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_r;
    logic        use1;
    logic        sub;
    logic        Cin;
    logic [15:0] A;
    logic [15:0] B;

    logic        start0, start1;
    logic [15:0] S0, S1;
    logic        Cout0, Cout1, V0, V1, busy0, busy1, done0, done1;
    logic [15:0] so;
    logic        co, vo, bo, dn;

    assign start0 = start_r & ~use1;
    assign start1 = start_r & use1;
    assign so = use1 ? S1 : S0;
    assign co = use1 ? Cout1 : Cout0;
    assign vo = use1 ? V1 : V0;
    assign bo = use1 ? busy1 : busy0;
    assign dn = use1 ? done1 : done0;

    digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .start(start0), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .S(S0), .Cout(Cout0), .V(V0), .busy(busy0), .done(done0)
    );

    digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub), .A(A), .B(B), .Cin(Cin),
        .S(S1), .Cout(Cout1), .V(V1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sb;
        logic [15:0] s;
        logic        co;
        logic        v;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sb);
        int          sa, sbv, r;
        int unsigned u;
        logic [15:0] s;
        logic        c, v;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (sb) begin
            r = sa - sbv;
            c = (a >= b);
            s = a - b;
        end else begin
            r = sa + sbv + int'(ci);
            u = 32'(a) + 32'(b) + 32'(ci);
            c = (u > 32'd65535);
            s = u[15:0];
        end
        v = (r > 32767) || (r < -32768);
        return {v, c, s};
    endfunction

    // Drives one operation, scrambles inputs during RUN, checks timing and result.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic sb, input logic [15:0] es, input logic ec,
                          input logic ev, input int nd, input logic first, input string nm);
        if (!first) @(negedge clk);
        A = a; B = b; Cin = ci; sub = sb; start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        A = 16'($urandom); B = 16'($urandom);
        Cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        chk({nm, " busy0"}, 32'(bo), 32'd1);
        chk({nm, " done0"}, 32'(dn), 32'd0);
        for (int n = 1; n <= nd; n++) begin
            @(negedge clk);
            if (n < nd) begin
                chk({nm, " busy_run"}, 32'(bo), 32'd1);
                chk({nm, " done_early"}, 32'(dn), 32'd0);
            end else begin
                chk({nm, " done"}, 32'(dn), 32'd1);
                chk({nm, " busy_end"}, 32'(bo), 32'd0);
                chk({nm, " S"}, 32'(so), 32'(es));
                chk({nm, " Cout"}, 32'(co), 32'(ec));
                chk({nm, " V"}, 32'(vo), 32'(ev));
            end
        end
        @(negedge clk);
        chk({nm, " done_pulse"}, 32'(dn), 32'd0);
        chk({nm, " S_hold"}, 32'(so), 32'(es));
    endtask

    initial begin
        logic [17:0] m;
        logic [15:0] ra, rb;
        logic        rc, rs;
        int          ndone;

        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        // Reset, with start held high to confirm it is ignored.
        rst = 1'b1; start_r = 1'b1; use1 = 1'b0;
        A = 16'h1234; B = 16'h4321; Cin = 1'b0; sub = 1'b0;
        #1;
        chk("rst S", 32'(so), 32'd0);
        chk("rst Cout", 32'(co), 32'd0);
        chk("rst V", 32'(vo), 32'd0);
        chk("rst done", 32'(dn), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(bo), 32'd0);
        start_r = 1'b0;

        // First start right after reset release.
        @(negedge clk);
        rst = 1'b0;
        run_op(tbl[0].a, tbl[0].b, tbl[0].cin, tbl[0].sb, tbl[0].s, tbl[0].co, tbl[0].v,
               4, 1'b1, "first");

        for (int i = 0; i < 7; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sb, tbl[i].s, tbl[i].co, tbl[i].v,
                   4, 1'b0, $sformatf("vec%0d", i));

        // Reset mid-RUN: Cout/V are 1 from the last vector, S partially updated.
        @(negedge clk);
        A = 16'h1234; B = 16'h4321; Cin = 1'b0; sub = 1'b0; start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort S", 32'(so), 32'd0);
        chk("abort Cout", 32'(co), 32'd0);
        chk("abort V", 32'(vo), 32'd0);
        chk("abort busy", 32'(bo), 32'd0);
        chk("abort done", 32'(dn), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (dn) ndone++;
        end
        chk("abort no_done", 32'(ndone), 32'd0);
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 4, 1'b0, "post_abort");

        // Disturb operands and pulse start during RUN.
        @(negedge clk);
        A = 16'h1234; B = 16'h4321; Cin = 1'b0; sub = 1'b0; start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0; A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1; sub = 1'b1;
        @(negedge clk);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        @(negedge clk);
        chk("disturb early", 32'(dn), 32'd0);
        @(negedge clk);
        chk("disturb done", 32'(dn), 32'd1);
        chk("disturb S", 32'(so), 32'h5555);
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (dn) ndone++;
        end
        chk("disturb one_pulse", 32'(ndone), 32'd0);

        // Back-to-back: start held high through DONE.
        @(negedge clk);
        A = 16'hFFFF; B = 16'h0001; Cin = 1'b0; sub = 1'b0; start_r = 1'b1;
        @(negedge clk);
        A = 16'h0005; B = 16'h0007; Cin = 1'b1; sub = 1'b1;
        chk("b2b busy1", 32'(bo), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("b2b early1", 32'(dn), 32'd0);
        end
        @(negedge clk);
        chk("b2b done1", 32'(dn), 32'd1);
        chk("b2b S1", 32'(so), 32'h0000);
        chk("b2b Cout1", 32'(co), 32'd1);
        chk("b2b V1", 32'(vo), 32'd0);
        @(negedge clk);
        start_r = 1'b0;
        chk("b2b busy2", 32'(bo), 32'd1);
        chk("b2b pulse", 32'(dn), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("b2b early2", 32'(dn), 32'd0);
        end
        @(negedge clk);
        chk("b2b done2", 32'(dn), 32'd1);
        chk("b2b S2", 32'(so), 32'hFFFE);
        chk("b2b Cout2", 32'(co), 32'd0);
        chk("b2b V2", 32'(vo), 32'd0);
        @(negedge clk);

        // Randomized against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            m = model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, m[15:0], m[16], m[17], 4, 1'b0, $sformatf("rnd%0d", i));
        end

        // Single-digit instance.
        use1 = 1'b1;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1, 1'b0, "n1 basic");
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            m = model(ra, rb, rc, rs);
            run_op(ra, rb, rc, rs, m[15:0], m[16], m[17], 1, 1'b0, $sformatf("n1rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/digit_serial_addsub.md
DIGIT_SERIAL_ADDSUB -- requirements
Module: digit_serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter DIGIT, default 4: bits processed per clock.
- WIDTH SHALL be an integer multiple of DIGIT.
- NDIG = WIDTH/DIGIT.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  request to begin an operation.
REQ-006 sub  input  1  mode select: 0 = A+B+Cin, 1 = A-B.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 Cin  input  1  carry-in; used in add mode only.
REQ-010 S  output  WIDTH  registered result.
REQ-011 Cout  output  1  carry-out of the MSB; in sub mode, 1 = no borrow.
REQ-012 V  output  1  two's-complement signed overflow.
REQ-013 busy  output  1  high while an operation is in progress.
REQ-014 done  output  1  one-cycle pulse marking S/Cout/V valid.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 Start acceptance SHALL be as follows:
- In IDLE or DONE, a rising edge with start=1 SHALL capture the operands.
  - A is captured as-is.
  - B is captured as-is (sub=0) or bitwise inverted (sub=1).
- The carry register SHALL load Cin (sub=0) or 1 (sub=1).
- The digit counter SHALL clear to 0, state SHALL go to RUN, and busy SHALL go to 1 on the same edge.
REQ-017 In RUN, each rising edge SHALL add digit k of the captured operands plus the carry register through a DIGIT-bit ripple full-adder chain.
- Sum bit: S[i] = a^b^c.
- Carry: c[i+1] = a&b | c&(a^b).
- The result SHALL be written into S[k*DIGIT +: DIGIT].
- The chain carry-out SHALL be stored and k incremented.
REQ-018 SHALL hold the captured operands stable during RUN; changes on A, B, Cin, or sub during RUN SHALL NOT affect the result.
REQ-019 start asserted during RUN SHALL be ignored, with no queuing and no restart.
REQ-020 On the edge that processes digit NDIG-1:
- State SHALL go to DONE.
- Cout SHALL take the final carry.
- V SHALL equal (carry into MSB) XOR (carry out of MSB).
- busy SHALL go to 0 and done SHALL go to 1.
REQ-021 Latency: done SHALL be high for exactly the cycle following edge t0+NDIG, where t0 is the accepting edge.
REQ-022 done SHALL deassert on the next edge.
- DONE SHALL go to IDLE, or to RUN if start=1 on that edge (back-to-back operation, no idle cycle).
REQ-023 S, Cout, and V SHALL hold their values from DONE until the next accepted start.
- Partial S bits MAY update during RUN.
- Cout and V SHALL change only at the DONE transition.
REQ-024 Edge case DIGIT=WIDTH (NDIG=1): the result SHALL be produced in one RUN edge, with done high in the cycle after t0+1.
REQ-025 The digit counter SHALL be ceil(log2(NDIG+1)) bits wide minimum and SHALL NOT wrap during an operation.
REQ-026 In sub mode, Cin SHALL be ignored.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for clk, force:
- state IDLE, counter 0, carry 0;
- S=0, Cout=0, V=0, busy=0, done=0.
REQ-028 Reset during RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-029 The first start SHALL be accepted on the first rising edge after rst deasserts.
REQ-030 While rst=1, start SHALL be ignored.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-031 Add, basic: A=0x1234, B=0x4321, Cin=0, sub=0 -> S=0x5555, Cout=0, V=0; done exactly 4 edges after the accepting edge; busy high for those 4 cycles.
REQ-032 Add, carry/overflow:
- A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1, V=0.
- A=0x7FFF, B=0x0000, Cin=1 -> S=0x8000, Cout=0, V=1.
REQ-033 Subtract:
- A=0x0005, B=0x0007, sub=1 -> S=0xFFFE, Cout=0, V=0.
- A=0x8000, B=0x0001, sub=1 -> S=0x7FFF, Cout=1, V=1.
REQ-034 Mid-op disturbance: after start, change A/B to 0xFFFF and pulse start during RUN -> result unchanged from the captured operands; exactly one done pulse.
REQ-035 Back-to-back: start held high through DONE -> second operation begins the edge after done; results correct for both; no idle gap.
REQ-036 Reset abort and NDIG=1:
- Assert rst asynchronously mid-RUN -> all outputs 0 before the next edge; no done pulse; a subsequent operation completes correctly.
- Repeat REQ-031 with DIGIT=16 -> done 1 edge after the accepting edge.
